// File: rtl/adder_pkg.sv
// Shared configuration constants and helpers for the pipelined adder.
// The optional PIPELINED_ADDER_OVERFLOW_EN macro is handled in the modules, not here.
package adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    // Bits handled by one pipeline slice.
    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    // Legal configuration: every slice gets the same non-empty chunk.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder.
// ovf exists only when PIPELINED_ADDER_OVERFLOW_EN is defined.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = adder_pkg::DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , input ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/pipelined_adder_slice.sv
// One CHUNK-bit registered adder slice with carry in/out.
// With PIPELINED_ADDER_OVERFLOW_EN, a slice built with OVF=1 also registers signed overflow.
module pipelined_adder_slice #(
    parameter int unsigned CHUNK = 8
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , parameter bit OVF = 1'b0
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    , output logic           ovf
`endif
);

    logic [CHUNK-1:0] sum_c;
    logic             cout_c;

    always_comb begin
        {cout_c, sum_c} = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= sum_c;
            cout <= cout_c;
        end
    end

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    // Overflow = carry into MSB xor carry out of MSB; carry into MSB recovered from the MSB sum bit.
    if (OVF) begin : g_ovf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf <= 1'b0;
            end else if (en) begin
                ovf <= cout_c ^ (a[CHUNK-1] ^ b[CHUNK-1] ^ sum_c[CHUNK-1]);
            end
        end
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end
`endif

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES registered slices with valid/ready handshakes.
// Define PIPELINED_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic              advance;
    logic [STAGES-1:0] vld_q;
    logic [CHUNK-1:0]  slice_a   [STAGES];
    logic [CHUNK-1:0]  slice_b   [STAGES];
    logic [CHUNK-1:0]  slice_sum [STAGES];
    logic [STAGES-1:0] slice_cin;
    logic [STAGES-1:0] slice_cout;
    logic [WIDTH-1:0]  sum_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic [STAGES-1:0] slice_ovf;
`endif

    // Whole pipeline moves as one unit; it only stops when a result is waiting on the consumer.
    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[0] <= bus.in_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int unsigned DESKEW = STAGES - 1 - unsigned'(k);

        if (k == 0) begin : g_direct
            assign slice_a[k]   = bus.a[CHUNK-1:0];
            assign slice_b[k]   = bus.b[CHUNK-1:0];
            assign slice_cin[k] = bus.ci;
        end else begin : g_skew
            // Chunk k waits k cycles so it meets the carry rippling up from slice k-1.
            logic [CHUNK-1:0] a_sr [k];
            logic [CHUNK-1:0] b_sr [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_sr[i] <= '0;
                        b_sr[i] <= '0;
                    end
                end else if (advance) begin
                    a_sr[0] <= bus.a[k*CHUNK +: CHUNK];
                    b_sr[0] <= bus.b[k*CHUNK +: CHUNK];
                    for (int i = 1; i < k; i++) begin
                        a_sr[i] <= a_sr[i-1];
                        b_sr[i] <= b_sr[i-1];
                    end
                end
            end

            assign slice_a[k]   = a_sr[k-1];
            assign slice_b[k]   = b_sr[k-1];
            assign slice_cin[k] = slice_cout[k-1];
        end

        pipelined_adder_slice #(
            .CHUNK (CHUNK)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            , .OVF (k == STAGES - 1)
`endif
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (advance),
            .a     (slice_a[k]),
            .b     (slice_b[k]),
            .cin   (slice_cin[k]),
            .sum   (slice_sum[k]),
            .cout  (slice_cout[k])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            , .ovf (slice_ovf[k])
`endif
        );

        if (DESKEW == 0) begin : g_no_deskew
            assign sum_out[k*CHUNK +: CHUNK] = slice_sum[k];
        end else begin : g_deskew
            // Early chunks wait for the later slices so the whole sum leaves together.
            logic [CHUNK-1:0] s_sr [DESKEW];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DESKEW); i++) begin
                        s_sr[i] <= '0;
                    end
                end else if (advance) begin
                    s_sr[0] <= slice_sum[k];
                    for (int i = 1; i < int'(DESKEW); i++) begin
                        s_sr[i] <= s_sr[i-1];
                    end
                end
            end

            assign sum_out[k*CHUNK +: CHUNK] = s_sr[DESKEW-1];
        end
    end

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.s         = sum_out;
    assign bus.co        = slice_cout[STAGES-1];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    // Only the final slice computes overflow; the others tie their flag low.
    assign bus.ovf       = |slice_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8, STAGES=2); covers ovf when
// PIPELINED_ADDER_OVERFLOW_EN is defined.
module tb_pipelined_adder;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer addition, {co, s}.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int t;
        t = int'(a) + int'(b) + int'(ci);
        return t[W:0];
    endfunction

    // Reference: true signed result falls outside the W-bit two's complement range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int sa, sb, r;
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        r  = sa + sb + int'(ci);
        return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic rdy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.ci        = ci;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.co, bus.s} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b co=%b s=%h, expected 0/0/00", bus.out_valid, bus.co, bus.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        for (int i = 1; i <= int'(S); i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (i < int'(S)) begin
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL single_early_valid: cycle %0d got %b expected 0", i, bus.out_valid);
                end
            end else if ({bus.out_valid, bus.co, bus.s} !== {1'b1, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL single_result: got valid=%b co=%b s=%h, expected 1/1/00", bus.out_valid, bus.co, bus.s);
            end
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [3] = '{8'h12, 8'h80, 8'h0F};
        logic [W-1:0] tb [3] = '{8'h34, 8'h80, 8'hF0};
        logic         tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [3] = '{8'h46, 8'h01, 8'h00};
        logic         ec [3] = '{1'b0, 1'b1, 1'b1};
        for (int c = 0; c < int'(S) + 4; c++) begin
            if (c < 3) drive(1'b1, ta[c], tb[c], tc[c], 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (c >= int'(S) && c < int'(S) + 3) begin
                if ({bus.out_valid, bus.co, bus.s} !== {1'b1, ec[c-S], es[c-S]}) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got valid=%b co=%b s=%h, expected 1/%b/%h",
                             c - int'(S), bus.out_valid, bus.co, bus.s, ec[c-S], es[c-S]);
                end
            end else if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle_valid: cycle %0d got %b expected 0", c, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] oa [S];
        logic [W-1:0] ob [S];
        logic         oc [S];
        logic [W:0]   ex [S];
        for (int i = 0; i < int'(S); i++) begin
            oa[i] = W'($urandom);
            ob[i] = W'($urandom);
            oc[i] = 1'($urandom_range(0, 1));
            ex[i] = ref_sum(oa[i], ob[i], oc[i]);
        end
        for (int c = 0; c < int'(S); c++) drive(1'b1, oa[c], ob[c], oc[c], 1'b1);
        // Consumer stalls; the producer keeps offering junk that must be ignored.
        for (int h = 0; h < 3; h++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready: stall %0d got %b expected 0", h, bus.in_ready);
            end
            checks++;
            if ({bus.out_valid, bus.co, bus.s} !== {1'b1, ex[0]}) begin
                errors++;
                $display("FAIL bp_hold: stall %0d got valid=%b {co,s}=%h expected 1/%h", h, bus.out_valid, {bus.co, bus.s}, ex[0]);
            end
        end
        for (int j = 0; j < int'(S); j++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if ({bus.out_valid, bus.co, bus.s} !== {1'b1, ex[j]}) begin
                errors++;
                $display("FAIL bp_drain%0d: got valid=%b {co,s}=%h expected 1/%h", j, bus.out_valid, {bus.co, bus.s}, ex[j]);
            end
        end
        for (int j = 0; j < 2; j++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_extra_output: cycle %0d got valid=%b expected 0", j, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        drive(1'b1, 8'h56, 8'h78, 1'b1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.co, bus.s} !== '0) begin
            errors++;
            $display("FAIL midrst_clear: got valid=%b co=%b s=%h, expected 0/0/00", bus.out_valid, bus.co, bus.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(S) + 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale: cycle %0d got valid=%b expected 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_aa55();
        drive(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);
        for (int i = 1; i <= int'(S); i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            checks++;
            if (i < int'(S)) begin
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL aa55_early_valid: cycle %0d got %b expected 0", i, bus.out_valid);
                end
            end else if ({bus.out_valid, bus.co, bus.s} !== {1'b1, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL aa55_result: got valid=%b co=%b s=%h, expected 1/1/00", bus.out_valid, bus.co, bus.s);
            end
        end
    endtask

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [W-1:0] ta [2] = '{8'h7F, 8'h80};
        logic [W-1:0] tb [2] = '{8'h01, 8'hFF};
        logic [W-1:0] es [2] = '{8'h80, 8'h7F};
        logic         ec [2] = '{1'b0, 1'b1};
        for (int c = 0; c < int'(S) + 2; c++) begin
            if (c < 2) drive(1'b1, ta[c], tb[c], 1'b0, 1'b1);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (c >= int'(S)) begin
                checks++;
                if ({bus.out_valid, bus.co, bus.s, bus.ovf} !== {1'b1, ec[c-S], es[c-S], 1'b1}) begin
                    errors++;
                    $display("FAIL ovf_result%0d: got valid=%b co=%b s=%h ovf=%b, expected 1/%b/%h/1",
                             c - int'(S), bus.out_valid, bus.co, bus.s, bus.ovf, ec[c-S], es[c-S]);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [W:0]   q_sum [$];
        logic         q_ovf [$];
        logic [W:0]   want;
        logic         want_ovf;
        logic         v, rdy, ci;
        logic [W-1:0] a, b;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 7);
            a   = W'($urandom);
            b   = W'($urandom);
            ci  = 1'($urandom_range(0, 1));
            drive(v, a, b, ci, rdy);
            checks++;
            if (bus.in_ready !== (!bus.out_valid || rdy)) begin
                errors++;
                $display("FAIL rand_in_ready: cycle %0d got %b with out_valid=%b out_ready=%b", c, bus.in_ready, bus.out_valid, rdy);
            end
            if (bus.out_valid && rdy) begin
                checks++;
                if (q_sum.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: cycle %0d got {co,s}=%h with nothing outstanding", c, {bus.co, bus.s});
                end else begin
                    want     = q_sum.pop_front();
                    want_ovf = q_ovf.pop_front();
                    if ({bus.co, bus.s} !== want) begin
                        errors++;
                        $display("FAIL rand_result: cycle %0d got {co,s}=%h expected %h", c, {bus.co, bus.s}, want);
                    end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    checks++;
                    if (bus.ovf !== want_ovf) begin
                        errors++;
                        $display("FAIL rand_ovf: cycle %0d got %b expected %b", c, bus.ovf, want_ovf);
                    end
`endif
                end
            end
            if (v && bus.in_ready) begin
                q_sum.push_back(ref_sum(a, b, ci));
                q_ovf.push_back(ref_ovf(a, b, ci));
            end
        end
        // Drain whatever is still in flight, bounded.
        for (int c = 0; c < 4 * int'(S) + 8 && q_sum.size() > 0; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            if (bus.out_valid) begin
                checks++;
                want     = q_sum.pop_front();
                want_ovf = q_ovf.pop_front();
                if ({bus.co, bus.s} !== want) begin
                    errors++;
                    $display("FAIL drain_result: got {co,s}=%h expected %h", {bus.co, bus.s}, want);
                end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                checks++;
                if (bus.ovf !== want_ovf) begin
                    errors++;
                    $display("FAIL drain_ovf: got %b expected %b", bus.ovf, want_ovf);
                end
`endif
            end
        end
        checks++;
        if (q_sum.size() != 0) begin
            errors++;
            $display("FAIL rand_lost: %0d results never emerged, expected 0", q_sum.size());
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_aa55();
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
